escalonador_tempo: RTL and testbench
====================================

# escalonador_tempo

Round-robin scheduler that shares one seconds countdown timer between three requesters (motor, LEDs, buzzer) of the toy automation. It takes the 1 Hz square wave from the clock divider, synchronizes it into the system clock domain, and turns it into one-cycle tick events. It grants the timer to one requester at a time for a selectable 1/2/4/8 s interval and pulses that requester's `done` bit when the interval expires.

## Interface
- `N_REQ`, 3: number of requesters; fixed at 3 in this revision.
- `clk`  in  1  system clock, 50 MHz; all flops on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clk_1s`  in  1  1 Hz square wave from the divider; treated as asynchronous; high and low phases each ≥ 2 `clk` cycles.
- `req`  in  3  level request per requester; held until `done` or until the requester gives up.
- `dur_sel`  in  6  2 bits per requester (`[2i+1:2i]`): 00 = 2 s, 01 = 4 s, 10 = 8 s, 11 = 1 s.
- `gnt`  out  3  one-hot grant; high for the whole timed interval.
- `busy`  out  1  timer in use (state RUN or DONE).
- `done`  out  3  one-cycle pulse on the bit of the requester whose interval expired.
- `remaining`  out  4  seconds (ticks) left in the current interval; 0 when idle.

## Operation
- Tick generation:
  - 2-flop synchronizer on `clk_1s`, plus a third flop that holds the previous value.
  - `tick` = sync2 & ~sync3 (one `clk` cycle per rising edge of `clk_1s`).
  - All three flops reset to 1, so a high `clk_1s` at reset release produces no spurious tick.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - If any `req` bit is high, grant one by round-robin.
  - Search order starts at the requester after `last`: (`last`+1, `last`+2, `last`), modulo 3.
  - At the grant, load `remaining` from the granted requester's `dur_sel` (2/4/8/1), set `gnt`, register `last` = winner, go to RUN.
- RUN:
  - Each `tick` decrements `remaining`.
  - A tick while `remaining` = 1 sets `remaining` to 0 and moves to DONE.
  - If the granted requester's `req` drops, abort: clear `gnt`, set `remaining` to 0, go to IDLE, no `done` pulse. Abort takes priority over a same-cycle tick.
- DONE (exactly one cycle):
  - `done[winner]` = 1, `gnt` = 0, `busy` = 1.
  - Next state is IDLE. No grant is issued in the DONE cycle.
- `dur_sel` is sampled only at grant; later changes are ignored until the next grant.
- A requester that keeps `req` high after its `done` is re-arbitrated normally. Round-robin serves the other pending requesters first.
- `last` resets to 2, so requester 0 has first priority after reset.

## Timing
- Reset values: `gnt` = 000, `done` = 000, `busy` = 0, `remaining` = 0, state IDLE, `last` = 2, sync chain = 111.
- `tick` rises 2–3 `clk` cycles after a `clk_1s` rising edge and lasts 1 cycle.
- Grant latency:
  - `gnt` and `busy` rise on the clock edge after `req` is sampled high in IDLE.
  - `remaining` is valid in the same cycle as `gnt`.
- A tick in the same cycle as the grant edge is not counted. Counting starts with the first tick after `gnt` is high.
- Interval = N ticks after grant, so real time is in (N−1, N] seconds.
- `done` is asserted the cycle after the final tick. `gnt` falls on that same edge.
- Minimum gap between two grants is 2 cycles (DONE, then IDLE).
- Abort: `gnt` falls on the clock edge after `req[winner]` is seen low.
- Reset asserted mid-interval: all outputs go to their reset values immediately (asynchronous). After release, the FSM starts in IDLE.

## Test plan
- Single request:
  - Stimulus: `req` = 001, `dur_sel[1:0]` = 00.
  - Response: `gnt` = 001 and `remaining` = 2 one cycle later; 1 after the first tick, 0 after the second; `done` = 001 for 1 cycle; then `gnt` = 000, `busy` = 0.
- Round-robin:
  - Stimulus: `req` = 111 held, all durations 11.
  - Response: grants in order 001, 010, 100, 001, each lasting 1 tick, each followed by a 1-cycle `done` on the same bit.
- Abort:
  - Stimulus: grant requester 1 with 8 s; drop `req[1]` after 3 ticks.
  - Response: `gnt` = 000, `remaining` = 0 next cycle; no `done` pulse; a pending `req[2]` is granted 1 cycle later.
- Boundary collisions:
  - Tick in the same cycle as the grant: `remaining` stays 4 for `dur_sel` = 01.
  - Tick in the same cycle as abort: abort wins, no `done`.
- Reset:
  - Stimulus: hold `clk_1s` = 1 through `rst_n` release.
  - Response: no tick until the next real rising edge.
  - Stimulus: assert `rst_n` = 0 mid-RUN.
  - Response: all outputs 0 immediately; `last` = 2.
- Sampling and DONE cycle:
  - Stimulus: change `dur_sel` during RUN.
  - Response: `remaining` is unaffected.
  - Stimulus: keep `req` = 001 high through DONE.
  - Response: re-grant occurs 2 cycles after `done`, not in the DONE cycle.

Source files
------------

// File: rtl/escalonador_tempo.sv
// escalonador_tempo: round-robin owner of a shared seconds countdown timer.
// Synchronizes the 1 Hz square wave into the system clock domain, converts
// each rising edge into a one-cycle tick, and grants the timer to one of
// three requesters for a 1/2/4/8 tick interval, pulsing done on expiry.
//
//   state  | meaning
//   IDLE   | timer free; arbitrate pending requests round-robin
//   RUN    | timer owned by requester last_q; counting ticks down
//   DONE   | single cycle; done[last_q] pulses, no new grant issued
module escalonador_tempo #(
  parameter int N_REQ = 3  // the wrap-around arithmetic below assumes exactly 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_1s,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] dur_sel,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic [N_REQ-1:0]   done,
  output logic [3:0]         remaining
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  rem_q, rem_d;
  // sync_q[0] = first sync flop, [1] = second sync flop, [2] = previous value
  logic [2:0]  sync_q, sync_d;
  logic        tick;

  logic        win_vld;
  logic [1:0]  win_idx;
  logic [2:0]  rr_sum;
  logic [1:0]  rr_cand;
  logic [2:0]  last_oh;

  // Duration code to tick count: 00=2, 01=4, 10=8, 11=1.
  function automatic logic [3:0] dur_secs(input logic [1:0] code);
    case (code)
      2'b00:   return 4'd2;
      2'b01:   return 4'd4;
      2'b10:   return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

  // Shift the async 1 Hz wave through the synchronizer and edge-detect flop.
  always_comb begin
    sync_d = {sync_q[1:0], clk_1s};
  end

  assign tick = sync_q[1] & ~sync_q[2];

  // Round-robin search starting after the previous winner: last+1, last+2, last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = last_q;
    rr_sum  = 3'd0;
    rr_cand = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      rr_sum  = {1'b0, last_q} + 3'(i);
      rr_cand = (rr_sum >= 3'd3) ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
      if (!win_vld && req[rr_cand]) begin
        win_vld = 1'b1;
        win_idx = rr_cand;
      end
    end
  end

  // Next-state logic: grant in IDLE, count ticks (abort has priority) in RUN.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        rem_d = 4'd0;
        if (win_vld) begin
          state_d = S_RUN;
          last_d  = win_idx;
          rem_d   = dur_secs(dur_sel[{win_idx, 1'b0} +: 2]);
        end
      end
      S_RUN: begin
        if (!req[last_q]) begin
          state_d = S_IDLE;
          rem_d   = 4'd0;
        end else if (tick) begin
          if (rem_q <= 4'd1) begin
            state_d = S_DONE;
            rem_d   = 4'd0;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rem_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = 4'd0;
      end
    endcase
  end

  // State, owner, countdown and synchronizer registers; sync chain resets high
  // so a wave already high at reset release does not produce a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 2'd2;
      rem_q   <= 4'd0;
      sync_q  <= 3'b111;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      sync_q  <= sync_d;
    end
  end

  // Outputs decode straight from registered state and owner.
  always_comb begin
    last_oh   = 3'b001 << last_q;
    gnt       = (state_q == S_RUN)  ? last_oh : 3'b000;
    done      = (state_q == S_DONE) ? last_oh : 3'b000;
    busy      = (state_q != S_IDLE);
    remaining = rem_q;
  end

endmodule

// File: tb/tb_escalonador_tempo.sv
// Testbench for escalonador_tempo: directed vector table, corner-case
// sequences and randomized traffic against a behavioural scheduler model.
module tb_escalonador_tempo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clk_1s = 1'b1;
  logic [2:0] req = 3'b000;
  logic [5:0] dur_sel = 6'b000000;
  logic [2:0] gnt;
  logic       busy;
  logic [2:0] done;
  logic [3:0] remaining;

  escalonador_tempo #(.N_REQ(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_1s    (clk_1s),
    .req       (req),
    .dur_sel   (dur_sel),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timer owner (-1 = nobody), seconds left, previous winner, and whether
  // the one-cycle completion slot is active. hist[j] is the wave value the
  // design sampled j+1 edges ago; a tick is seen when the value sampled two
  // edges ago is high and the one sampled three edges ago is low.
  int m_owner, m_left, m_last, m_done_who;
  bit m_in_done;
  bit hist[3];

  function automatic int secs(input logic [1:0] c);
    case (c)
      2'b00:   return 2;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = -1; m_left = 0; m_last = 2; m_done_who = 0; m_in_done = 0;
    hist[0] = 1; hist[1] = 1; hist[2] = 1;
  endtask

  task automatic model_edge();
    bit tk;
    int c;
    tk = hist[1] & ~hist[2];
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = clk_1s;
    if (m_in_done) begin
      m_in_done = 0;
    end else if (m_owner < 0) begin
      for (int i = 1; i <= 3; i++) begin
        c = (m_last + i) % 3;
        if (m_owner < 0 && req[c]) begin
          m_owner = c; m_last = c; m_left = secs(dur_sel[2*c +: 2]);
        end
      end
    end else if (!req[m_owner]) begin
      m_owner = -1; m_left = 0;
    end else if (tk) begin
      m_left--;
      if (m_left == 0) begin
        m_in_done = 1; m_done_who = m_owner; m_owner = -1;
      end
    end
  endtask

  task automatic model_check();
    logic [2:0] eg, ed;
    eg = 3'b000; ed = 3'b000;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    if (m_in_done) ed[m_done_who] = 1'b1;
    check("gnt", {5'd0, gnt}, {5'd0, eg});
    check("busy", {7'd0, busy}, {7'd0, (m_owner >= 0) || m_in_done});
    check("done", {5'd0, done}, {5'd0, ed});
    check("remaining", {4'd0, remaining}, 8'(m_left));
  endtask

  // ---------------- stimulus helpers ----------------
  bit auto_1s = 0;
  bit rand_half = 0;
  int half = 3;
  int ph = 0;

  // One clock: model updates on the edge, outputs checked on the falling edge,
  // then the 1 Hz wave advances if auto-generated.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
    if (auto_1s) begin
      ph++;
      if (ph >= half) begin
        ph = 0;
        clk_1s = ~clk_1s;
        if (rand_half) half = $urandom_range(2, 6);
      end
    end
  endtask

  task automatic do_reset(input logic c1s);
    rst_n = 1'b0;
    clk_1s = c1s;
    model_reset();
    #1;
    check("rst_gnt", {5'd0, gnt}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {5'd0, done}, 8'd0);
    check("rst_remaining", {4'd0, remaining}, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ph = 0;
  endtask

  typedef struct {
    logic [2:0] req;
    logic [5:0] dur;
    logic       c1s;
    logic [2:0] gnt;
    logic       busy;
    logic [2:0] done;
    logic [3:0] rem;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [2:0] order[4];
    logic [2:0] prev_g, last_g;
    int ng;

    // single request (2 s), dur_sel change while running, re-grant after DONE, abort
    vt[0]  = '{3'b000, 6'b000000, 1'b1, 3'b000, 1'b0, 3'b000, 4'd0};
    vt[1]  = '{3'b001, 6'b000000, 1'b1, 3'b001, 1'b1, 3'b000, 4'd2};
    vt[2]  = '{3'b001, 6'b000000, 1'b0, 3'b001, 1'b1, 3'b000, 4'd2};
    vt[3]  = '{3'b001, 6'b101010, 1'b0, 3'b001, 1'b1, 3'b000, 4'd2};
    vt[4]  = '{3'b001, 6'b101010, 1'b1, 3'b001, 1'b1, 3'b000, 4'd2};
    vt[5]  = '{3'b001, 6'b101010, 1'b1, 3'b001, 1'b1, 3'b000, 4'd2};
    vt[6]  = '{3'b001, 6'b101010, 1'b0, 3'b001, 1'b1, 3'b000, 4'd1};
    vt[7]  = '{3'b001, 6'b101010, 1'b0, 3'b001, 1'b1, 3'b000, 4'd1};
    vt[8]  = '{3'b001, 6'b101010, 1'b1, 3'b001, 1'b1, 3'b000, 4'd1};
    vt[9]  = '{3'b001, 6'b101010, 1'b1, 3'b001, 1'b1, 3'b000, 4'd1};
    vt[10] = '{3'b001, 6'b000000, 1'b0, 3'b000, 1'b1, 3'b001, 4'd0};
    vt[11] = '{3'b001, 6'b000000, 1'b0, 3'b000, 1'b0, 3'b000, 4'd0};
    vt[12] = '{3'b001, 6'b000000, 1'b0, 3'b001, 1'b1, 3'b000, 4'd2};
    vt[13] = '{3'b000, 6'b000000, 1'b0, 3'b000, 1'b0, 3'b000, 4'd0};

    #3;
    do_reset(1'b1);
    for (int k = 0; k < 14; k++) begin
      req = vt[k].req; dur_sel = vt[k].dur; clk_1s = vt[k].c1s;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_gnt", k), {5'd0, gnt}, {5'd0, vt[k].gnt});
      check($sformatf("vec%0d_busy", k), {7'd0, busy}, {7'd0, vt[k].busy});
      check($sformatf("vec%0d_done", k), {5'd0, done}, {5'd0, vt[k].done});
      check($sformatf("vec%0d_rem", k), {4'd0, remaining}, {4'd0, vt[k].rem});
    end

    // round-robin with all three requesting 1 s intervals
    req = 3'b000; dur_sel = 6'b000000;
    do_reset(1'b0);
    req = 3'b111; dur_sel = 6'b111111;
    auto_1s = 1; rand_half = 0; half = 3;
    ng = 0; prev_g = 3'b000; last_g = 3'b000;
    for (int i = 0; i < 4; i++) order[i] = 3'b000;
    for (int cyc = 0; cyc < 300 && ng < 4; cyc++) begin
      step();
      if (done != 3'b000) check("rr_done_bit", {5'd0, done}, {5'd0, last_g});
      if (prev_g == 3'b000 && gnt != 3'b000) begin
        order[ng] = gnt;
        last_g = gnt;
        ng++;
      end
      prev_g = gnt;
    end
    check("rr_grant_count", 8'(ng), 8'd4);
    check("rr_order0", {5'd0, order[0]}, 8'b001);
    check("rr_order1", {5'd0, order[1]}, 8'b010);
    check("rr_order2", {5'd0, order[2]}, 8'b100);
    check("rr_order3", {5'd0, order[3]}, 8'b001);

    // abort of requester 1 (8 s) after 3 ticks, with requester 2 pending
    auto_1s = 0;
    req = 3'b000;
    do_reset(1'b0);
    req = 3'b110; dur_sel = 6'b001000;
    auto_1s = 1; half = 3;
    for (int cyc = 0; cyc < 200 && remaining != 4'd5; cyc++) step();
    check("abort_wait_rem5", {4'd0, remaining}, 8'd5);
    check("abort_owner", {5'd0, gnt}, 8'b010);
    auto_1s = 0;
    req = 3'b100;
    step();
    check("abort_gnt", {5'd0, gnt}, 8'd0);
    check("abort_rem", {4'd0, remaining}, 8'd0);
    check("abort_done", {5'd0, done}, 8'd0);
    step();
    check("abort_next_gnt", {5'd0, gnt}, 8'b100);
    check("abort_next_rem", {4'd0, remaining}, 8'd2);

    // tick on the grant edge, then tick on the abort edge
    req = 3'b000;
    do_reset(1'b0);
    repeat (4) step();
    clk_1s = 1'b1;
    step();
    step();
    req = 3'b001; dur_sel = 6'b000001;
    step();
    check("tick_at_grant_gnt", {5'd0, gnt}, 8'b001);
    check("tick_at_grant_rem", {4'd0, remaining}, 8'd4);
    step();
    check("tick_at_grant_rem_hold", {4'd0, remaining}, 8'd4);
    clk_1s = 1'b0;
    step();
    step();
    clk_1s = 1'b1;
    step();
    step();
    check("pre_abort_rem", {4'd0, remaining}, 8'd4);
    req = 3'b000;
    step();
    check("tick_abort_gnt", {5'd0, gnt}, 8'd0);
    check("tick_abort_done", {5'd0, done}, 8'd0);
    check("tick_abort_rem", {4'd0, remaining}, 8'd0);
    step();
    check("tick_abort_done_after", {5'd0, done}, 8'd0);

    // wave high through reset release: no tick until a real rising edge
    do_reset(1'b1);
    req = 3'b001; dur_sel = 6'b000000;
    repeat (6) step();
    check("no_spurious_tick", {4'd0, remaining}, 8'd2);
    clk_1s = 1'b0;
    step(); step();
    clk_1s = 1'b1;
    step(); step(); step();
    check("first_real_tick", {4'd0, remaining}, 8'd1);

    // asynchronous reset in the middle of RUN, then requester 0 has priority
    #3;
    do_reset(1'b0);
    req = 3'b111; dur_sel = 6'b000000;
    step();
    check("post_reset_first_gnt", {5'd0, gnt}, 8'b001);

    // randomized traffic against the model
    req = 3'b000;
    do_reset(1'b0);
    auto_1s = 1; rand_half = 1; half = 3;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int b = 0; b < 3; b++) begin
        if (req[b]) begin
          if ($urandom_range(0, 59) == 0) req[b] = 1'b0;
          else if (m_in_done && m_done_who == b && $urandom_range(0, 1) == 0) req[b] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          req[b] = 1'b1;
        end
      end
      if ($urandom_range(0, 19) == 0) dur_sel = 6'($urandom_range(0, 63));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
